init_seq_ctrl: RTL
==================

Name: init_seq_ctrl

Overview:
- Start-up sequencer that removes the time-zero initialisation/edge race.
- After asynchronous reset, holds all capture logic in a known state for a programmable settle period.
- Then writes a known init value into every slot of a downstream register bank, one slot per cycle.
- Only after that does it open a valid/ready capture path. This guarantees the first sample can never observe X or a stale value.

Parameters:
- WIDTH, 8, data width of init_val, wr_data, d_data, q.
- DEPTH, 4, number of register-bank slots to initialise (>=1).
- AW, 2, wr_addr width, must satisfy 2**AW >= DEPTH.
- WAIT_CYCLES, 2, settle cycles after reset release before first write (>=1).
- CW, 4, settle counter width, must satisfy 2**CW > WAIT_CYCLES.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high; forces reset values immediately.
- init_val, input, WIDTH, value written to every bank slot during INIT.
- reinit, input, 1, single-cycle request to rerun the sequence; honoured only in RUN.
- wr_en, output, 1, bank write strobe (registered).
- wr_addr, output, AW, bank slot address (registered).
- wr_data, output, WIDTH, bank write data (registered).
- ready, output, 1, sequence complete; capture path open (registered).
- d_valid, input, 1, upstream data valid.
- d_data, input, WIDTH, upstream data.
- d_ready, output, 1, equals ready (direct from register, no combinational input path).
- q, output, WIDTH, captured data.
- q_valid, output, 1, q updated this cycle.

Behaviour:
- Reset values (asynchronous, while reset=1):
  - state=WAIT, cnt=0
  - wr_en=0, wr_addr=0, wr_data=0
  - ready=0, q=0, q_valid=0
- Edges are counted from the first posedge with reset=0 (edge 1).
- States: WAIT, INIT, RUN. Encoding is free; no other reachable state. An illegal encoding returns to WAIT.
- WAIT:
  - cnt increments each edge.
  - On the edge where cnt==WAIT_CYCLES-1: go to INIT, cnt<=0, wr_en<=1, wr_addr<=0, wr_data<=init_val.
  - Net effect: wr_en is first high after edge WAIT_CYCLES.
- INIT:
  - One write per cycle, wr_addr ascending 0..DEPTH-1.
  - wr_data re-samples init_val each edge.
  - On the edge leaving the slot at wr_addr==DEPTH-1: state<=RUN, wr_en<=0, wr_addr<=0, ready<=1.
  - Net effect: ready is first high after edge WAIT_CYCLES+DEPTH. Defaults give edge 6.
  - wr_addr never exceeds DEPTH-1; no wrap write.
- RUN:
  - ready=1 and d_ready=1.
  - Each edge with d_valid=1: q<=d_data, q_valid<=1.
  - Edge with d_valid=0: q holds, q_valid<=0.
  - Capture latency is 1 cycle.
- reinit in RUN:
  - Next edge: state<=WAIT, cnt<=0, ready<=0, q<=0, q_valid<=0.
  - Any d_valid on that same edge is dropped (reinit wins).
- reinit in WAIT or INIT: ignored; the sequence neither restarts nor extends.
- d_valid outside RUN: ignored; q and q_valid stay 0.
- Reset asserted mid-INIT or mid-RUN: all outputs take reset values immediately, without waiting for a clock. Sequence restarts from WAIT on release.
- Reset released coincident with a posedge: that edge is not counted. The first counted edge is the next one.
- No output may be X after reset has been asserted once, regardless of the X/0 state of clock at time zero.

Test Plan:
- Defaults; reset high 3 cycles then low; init_val=8'hA5 -> wr_en high after edges 2..5 with wr_addr 0,1,2,3 and wr_data A5. wr_en=0 and ready=1 from edge 6. q=0, q_valid=0 throughout.
- After ready: d_valid=1, d_data=8'h3C for 1 cycle, then d_valid=0 -> q=3C, q_valid=1 for exactly one cycle. q stays 3C afterwards.
- In RUN: reinit=1 together with d_valid=1, d_data=8'hFF -> next edge ready=0, q=0, q_valid=0 (FF not captured). Writes reappear 2 edges later; ready returns 6 edges after reinit.
- Reset asserted between posedges during INIT (wr_addr=2) -> wr_en, wr_addr and ready drop to 0 before the next posedge. After release, full sequence restarts with wr_addr 0.
- reinit pulsed during WAIT and during INIT, d_valid held 1 throughout -> write sequence timing unchanged; q_valid stays 0 until first edge after ready.
- Clock starting at X then 0 at time zero, reset high from time zero -> every output is 0 (never X) from the first delta after time zero.

Source files
------------

// File: rtl/init_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : init_seq_ctrl
// Purpose  : Start-up sequencer. After reset release it waits WAIT_CYCLES
//            edges, then writes init_val into every slot of a downstream
//            register bank (one slot per cycle, addresses 0..DEPTH-1), and
//            only then opens a valid/ready capture path. The first captured
//            sample therefore never sees an X or stale value.
// Ports    : clock     - single clock, posedge
//            reset     - asynchronous, active-high
//            init_val  - value written to every bank slot
//            reinit    - one-cycle request to rerun the sequence (RUN only)
//            wr_en     - bank write strobe            (registered)
//            wr_addr   - bank slot address            (registered)
//            wr_data   - bank write data              (registered)
//            ready     - sequence complete            (registered)
//            d_valid   - upstream data valid
//            d_data    - upstream data
//            d_ready   - copy of ready, straight from the flop
//            q         - captured data
//            q_valid   - q updated on the last edge
// Revision : 1.0 - initial release
// ============================================================================
module init_seq_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int AW          = 2,
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] init_val,
    input  logic             reinit,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             ready,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             d_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_CNT_LAST  = CW'(WAIT_CYCLES - 1);
    localparam logic [AW-1:0] C_ADDR_LAST = AW'(DEPTH - 1);

    state_t           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             wr_en_q,   wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             ready_q,   ready_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic             q_valid_q, q_valid_d;

    // State register: the asynchronous reset puts every output into its
    // known value immediately, so nothing downstream can ever observe X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ready_d   = ready_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;

        case (state_q)
            S_WAIT: begin
                // Capture path stays closed; reinit and d_valid are ignored.
                wr_en_d   = 1'b0;
                ready_d   = 1'b0;
                q_valid_d = 1'b0;
                if (cnt_q == C_CNT_LAST) begin
                    state_d   = S_INIT;
                    cnt_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = init_val;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_INIT: begin
                ready_d   = 1'b0;
                q_valid_d = 1'b0;
                wr_data_d = init_val;
                if (wr_addr_q == C_ADDR_LAST) begin
                    // Last slot written: stop before the address can wrap.
                    state_d   = S_RUN;
                    wr_en_d   = 1'b0;
                    wr_addr_d = '0;
                    ready_d   = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end

            S_RUN: begin
                if (reinit) begin
                    // reinit takes priority over a coincident d_valid.
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                    ready_d   = 1'b0;
                    q_d       = '0;
                    q_valid_d = 1'b0;
                end else if (d_valid) begin
                    q_d       = d_data;
                    q_valid_d = 1'b1;
                end else begin
                    q_valid_d = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean restart.
                state_d   = S_WAIT;
                cnt_d     = '0;
                wr_en_d   = 1'b0;
                wr_addr_d = '0;
                ready_d   = 1'b0;
                q_d       = '0;
                q_valid_d = 1'b0;
            end
        endcase
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign ready   = ready_q;
    assign d_ready = ready_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule
`default_nettype wire
